// File: rtl/dkong3_pkg.sv
// Shared definitions for the Donkey Kong 3 palette controller: FSM encoding
// and CLUT PROM geometry.
package dkong3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_1D = 3'd1,
    ST_LOAD_1C = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAIL    = 3'd4
  } pal_state_t;

  localparam int PAL_1D_SIZE   = 512;
  localparam int PAL_1C_OFFSET = 512;
  localparam int PAL_ENTRIES   = 256;

  // Bytes from PAL_BASE up to (but excluding) this offset belong to the palette.
  localparam int PAL_REGION_SPAN = PAL_1C_OFFSET + PAL_1D_SIZE;

endpackage

// File: rtl/dkong3_pal_ctrl_if.sv
// Palette bank-select bundle: vblank timing and CPU bank request in, applied
// bank out.
interface dkong3_pal_ctrl_if;

  logic       vblank;
  logic [1:0] cpu_sel;
  logic [1:0] applied_sel;

  modport master (
    output vblank,
    output cpu_sel,
    input  applied_sel
  );

  modport slave (
    input  vblank,
    input  cpu_sel,
    output applied_sel
  );

endinterface

// File: rtl/dkong3_pal_bank_sync.sv
// Vblank-edge bank latch: the CPU bank request only reaches the lookup on the
// cycle after vblank rises, so the palette never switches mid-frame.
module dkong3_pal_bank_sync (
  input  logic             clk,
  input  logic             srst,
  dkong3_pal_ctrl_if.slave bus
);

  logic [1:0] pending_q, pending_d;
  logic [1:0] sel_q, sel_d;
  logic       vblank_q, vblank_d;
  logic       vb_rise_q, vb_rise_d;

  always_comb begin
    pending_d = bus.cpu_sel;
    vblank_d  = bus.vblank;
    vb_rise_d = bus.vblank & ~vblank_q;
    sel_d     = sel_q;
    // The edge is registered first, giving the one-cycle deferral after vblank rises.
    if (vb_rise_q) begin
      sel_d = pending_q;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      pending_q <= 2'd0;
      sel_q     <= 2'd0;
      vblank_q  <= 1'b0;
      vb_rise_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      sel_q     <= sel_d;
      vblank_q  <= vblank_d;
      vb_rise_q <= vb_rise_d;
    end
  end

  assign bus.applied_sel = sel_q;

endmodule

// File: rtl/dkong3_pal_ctrl.sv
// Palette controller: sequences the download stream into CLUT PROMs 1D/1C,
// mutes video until both are loaded and defers bank changes to vblank.
module dkong3_pal_ctrl
  import dkong3_pkg::*;
#(
  parameter logic [17:0] PAL_BASE = 18'h0F000,
  parameter logic        CL1      = 1'b1
) (
  input  logic        I_CLK_24M,
  input  logic        I_RST,
  input  logic        I_DL_ACTIVE,
  input  logic        I_DL_WR,
  input  logic [17:0] I_DL_ADDR,
  input  logic [7:0]  I_DL_DATA,
  input  logic        I_VBLANK,
  input  logic [1:0]  I_CPAL_SEL,
  output logic        O_1D_WE,
  output logic        O_1C_WE,
  output logic [8:0]  O_PAL_WADDR,
  output logic [7:0]  O_PAL_WDATA,
  output logic [1:0]  O_CPAL_SEL,
  output logic        O_PAL_READY,
  output logic        O_VID_MUTE,
  output logic        O_ERR
);

  localparam logic [17:0] REGION_SPAN = 18'(PAL_REGION_SPAN);
  localparam logic [7:0]  LAST_ENTRY  = 8'(PAL_ENTRIES - 1);

  pal_state_t  state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        restart_q, restart_d;
  logic        dl_active_q;
  logic        we_1d_q, we_1d_d;
  logic        we_1c_q, we_1c_d;
  logic [8:0]  waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        mute_q, mute_d;
  logic        err_q, err_d;

  logic [17:0] off;
  logic        in_region;
  logic        wr_1d;
  logic        wr_1c;
  logic        dl_rise;
  logic        dl_fall;

  always_comb begin
    off       = I_DL_ADDR - PAL_BASE;
    in_region = (I_DL_ADDR >= PAL_BASE) && (off < REGION_SPAN);
    // off[8]=1 bytes belong to the unused palette half and are silently dropped.
    wr_1d     = I_DL_WR && in_region && !off[9] && !off[8];
    wr_1c     = I_DL_WR && in_region &&  off[9] && !off[8];
    dl_rise   =  I_DL_ACTIVE && !dl_active_q;
    dl_fall   = !I_DL_ACTIVE &&  dl_active_q;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    restart_d = restart_q;
    we_1d_d   = 1'b0;
    we_1c_d   = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    ready_d   = ready_q;
    mute_d    = mute_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        ptr_d     = 8'd0;
        ready_d   = 1'b0;
        mute_d    = 1'b1;
        restart_d = 1'b0;
        // restart_q carries the session-start edge that sent us back here.
        if (dl_rise || restart_q) begin
          state_d = ST_LOAD_1D;
        end
      end

      ST_LOAD_1D: begin
        if (dl_fall) begin
          err_d   = 1'b1;
          state_d = ST_FAIL;
        end else if (wr_1d) begin
          if (off[7:0] == ptr_q) begin
            we_1d_d = 1'b1;
            waddr_d = {CL1, ptr_q};
            wdata_d = I_DL_DATA;
            ptr_d   = ptr_q + 8'd1;
            if (ptr_q == LAST_ENTRY) begin
              state_d = ST_LOAD_1C;
            end
          end else begin
            err_d   = 1'b1;
            state_d = ST_FAIL;
          end
        end
      end

      ST_LOAD_1C: begin
        if (dl_fall) begin
          err_d   = 1'b1;
          state_d = ST_FAIL;
        end else if (wr_1c) begin
          if (off[7:0] == ptr_q) begin
            we_1c_d = 1'b1;
            waddr_d = {CL1, ptr_q};
            wdata_d = {4'h0, I_DL_DATA[3:0]};
            ptr_d   = ptr_q + 8'd1;
            if (ptr_q == LAST_ENTRY) begin
              state_d = ST_DONE;
              ready_d = 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = ST_FAIL;
          end
        end
      end

      ST_DONE: begin
        mute_d = 1'b0;
        if (dl_rise) begin
          state_d   = ST_IDLE;
          restart_d = 1'b1;
          ptr_d     = 8'd0;
          ready_d   = 1'b0;
          mute_d    = 1'b1;
          err_d     = 1'b0;
        end
      end

      ST_FAIL: begin
        mute_d  = 1'b1;
        ready_d = 1'b0;
        if (dl_rise) begin
          state_d   = ST_IDLE;
          restart_d = 1'b1;
          ptr_d     = 8'd0;
          err_d     = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_CLK_24M) begin
    if (I_RST) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 8'd0;
      restart_q   <= 1'b0;
      // Sampling the live level means a session held open across reset is not a new edge.
      dl_active_q <= I_DL_ACTIVE;
      we_1d_q     <= 1'b0;
      we_1c_q     <= 1'b0;
      waddr_q     <= 9'd0;
      wdata_q     <= 8'd0;
      ready_q     <= 1'b0;
      mute_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      restart_q   <= restart_d;
      dl_active_q <= I_DL_ACTIVE;
      we_1d_q     <= we_1d_d;
      we_1c_q     <= we_1c_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      mute_q      <= mute_d;
      err_q       <= err_d;
    end
  end

  dkong3_pal_ctrl_if bank_if ();

  assign bank_if.vblank  = I_VBLANK;
  assign bank_if.cpu_sel = I_CPAL_SEL;

  dkong3_pal_bank_sync u_bank_sync (
    .clk  (I_CLK_24M),
    .srst (I_RST),
    .bus  (bank_if.slave)
  );

  assign O_CPAL_SEL  = bank_if.applied_sel;
  assign O_1D_WE     = we_1d_q;
  assign O_1C_WE     = we_1c_q;
  assign O_PAL_WADDR = waddr_q;
  assign O_PAL_WDATA = wdata_q;
  assign O_PAL_READY = ready_q;
  assign O_VID_MUTE  = mute_q;
  assign O_ERR       = err_q;

endmodule

// File: tb/tb_dkong3_pal_ctrl.sv
// Directed bench for dkong3_pal_ctrl: PROM load sequencing, error paths,
// reset recovery and vblank-deferred bank switching.
module tb_dkong3_pal_ctrl;

  localparam logic [17:0] BASE = 18'h0F000;

  logic        clk;
  logic        rst;
  logic        dl_active;
  logic        dl_wr;
  logic [17:0] dl_addr;
  logic [7:0]  dl_data;
  logic        we1d;
  logic        we1c;
  logic [8:0]  waddr;
  logic [7:0]  wdata;
  logic        ready;
  logic        mute;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;

  dkong3_pal_ctrl_if tb_if ();

  dkong3_pal_ctrl #(.PAL_BASE(BASE), .CL1(1'b1)) dut (
    .I_CLK_24M   (clk),
    .I_RST       (rst),
    .I_DL_ACTIVE (dl_active),
    .I_DL_WR     (dl_wr),
    .I_DL_ADDR   (dl_addr),
    .I_DL_DATA   (dl_data),
    .I_VBLANK    (tb_if.vblank),
    .I_CPAL_SEL  (tb_if.cpu_sel),
    .O_1D_WE     (we1d),
    .O_1C_WE     (we1c),
    .O_PAL_WADDR (waddr),
    .O_PAL_WDATA (wdata),
    .O_CPAL_SEL  (tb_if.applied_sel),
    .O_PAL_READY (ready),
    .O_VID_MUTE  (mute),
    .O_ERR       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    strobe_cnt += int'(we1d) + int'(we1c);
    n_checks++;
    if (we1d === 1'b1 && we1c === 1'b1) begin
      n_fail++;
      $display("FAIL strobe_exclusive t=%0t: we1d=%b we1c=%b, required not both 1", $time, we1d, we1c);
    end
  end

  // Drives one download strobe and returns the write-port state one cycle later.
  task automatic dl_write(input logic [17:0] a, input logic [7:0] d,
                          output logic o1d, output logic o1c,
                          output logic [8:0] oa, output logic [7:0] od);
    @(negedge clk);
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    @(negedge clk);
    dl_wr = 1'b0;
    o1d = we1d;
    o1c = we1c;
    oa  = waddr;
    od  = wdata;
  endtask

  task automatic start_session();
    @(negedge clk);
    dl_active = 1'b0;
    repeat (2) @(negedge clk);
    dl_active = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_full_load(input string tag, input bit strays);
    logic o1d, o1c;
    logic [8:0] oa;
    logic [7:0] od;
    int cnt0;
    cnt0 = strobe_cnt;
    for (int i = 0; i < 256; i++) begin
      if (strays && i == 10) begin
        dl_write(BASE - 18'd1, 8'h11, o1d, o1c, oa, od);
        n_checks++;
        if (o1d !== 1'b0 || o1c !== 1'b0) begin
          n_fail++;
          $display("FAIL %s stray_below: we1d=%b we1c=%b, required 0 0", tag, o1d, o1c);
        end
        dl_write(BASE + 18'd256, 8'h22, o1d, o1c, oa, od);
        n_checks++;
        if (o1d !== 1'b0 || o1c !== 1'b0) begin
          n_fail++;
          $display("FAIL %s stray_half: we1d=%b we1c=%b, required 0 0", tag, o1d, o1c);
        end
        dl_write(BASE + 18'd1024, 8'h33, o1d, o1c, oa, od);
        n_checks++;
        if (o1d !== 1'b0 || o1c !== 1'b0 || err !== 1'b0) begin
          n_fail++;
          $display("FAIL %s stray_above: we1d=%b we1c=%b err=%b, required 0 0 0", tag, o1d, o1c, err);
        end
      end
      dl_write(BASE + 18'(i), 8'(i), o1d, o1c, oa, od);
      n_checks++;
      if (o1d !== 1'b1 || o1c !== 1'b0 || oa !== {1'b1, 8'(i)} || od !== 8'(i)) begin
        n_fail++;
        $display("FAIL %s 1d_entry%0d: we1d=%b we1c=%b waddr=%h wdata=%h, required 1 0 %h %h",
                 tag, i, o1d, o1c, oa, od, {1'b1, 8'(i)}, 8'(i));
      end
    end
    for (int i = 0; i < 256; i++) begin
      if (strays && i == 20) begin
        dl_write(BASE + 18'd768 + 18'd20, 8'h44, o1d, o1c, oa, od);
        n_checks++;
        if (o1d !== 1'b0 || o1c !== 1'b0) begin
          n_fail++;
          $display("FAIL %s stray_1c_half: we1d=%b we1c=%b, required 0 0", tag, o1d, o1c);
        end
      end
      dl_write(BASE + 18'd512 + 18'(i), 8'hA0 | 8'(i % 16), o1d, o1c, oa, od);
      n_checks++;
      if (o1d !== 1'b0 || o1c !== 1'b1 || oa !== {1'b1, 8'(i)} || od !== 8'(i % 16)) begin
        n_fail++;
        $display("FAIL %s 1c_entry%0d: we1d=%b we1c=%b waddr=%h wdata=%h, required 0 1 %h %h",
                 tag, i, o1d, o1c, oa, od, {1'b1, 8'(i)}, 8'(i % 16));
      end
    end
    n_checks++;
    if (oa !== 9'h1FF || ready !== 1'b1 || mute !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s load_end: waddr=%h ready=%b mute=%b err=%b, required 1ff 1 1 0",
               tag, oa, ready, mute, err);
    end
    @(negedge clk);
    n_checks++;
    if (mute !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s unmute: mute=%b ready=%b, required 0 1", tag, mute, ready);
    end
    n_checks++;
    if (strobe_cnt - cnt0 !== 512) begin
      n_fail++;
      $display("FAIL %s strobe_count: %0d, required 512", tag, strobe_cnt - cnt0);
    end
    $display("%s: full load finished, strobes=%0d", tag, strobe_cnt - cnt0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dl_active = 1'b0;
    dl_wr = 1'b0;
    dl_addr = 18'd0;
    dl_data = 8'd0;
    tb_if.vblank = 1'b0;
    tb_if.cpu_sel = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (we1d !== 1'b0 || we1c !== 1'b0 || waddr !== 9'd0 || wdata !== 8'd0 ||
        tb_if.applied_sel !== 2'd0 || ready !== 1'b0 || mute !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: we=%b%b waddr=%h wdata=%h sel=%0d ready=%b mute=%b err=%b, required 00 000 00 0 0 1 0",
               we1d, we1c, waddr, wdata, tb_if.applied_sel, ready, mute, err);
    end
    $display("test_reset: done");
  endtask

  task automatic test_full_load();
    start_session();
    do_full_load("full_load", 1'b0);
  endtask

  task automatic test_out_of_order();
    logic o1d, o1c;
    logic [8:0] oa;
    logic [7:0] od;
    start_session();
    n_checks++;
    if (ready !== 1'b0 || mute !== 1'b1) begin
      n_fail++;
      $display("FAIL ooo_restart: ready=%b mute=%b, required 0 1", ready, mute);
    end
    for (int i = 0; i < 4; i++) begin
      dl_write(BASE + 18'(i), 8'h50 + 8'(i), o1d, o1c, oa, od);
      n_checks++;
      if (o1d !== 1'b1 || oa !== {1'b1, 8'(i)} || od !== 8'h50 + 8'(i)) begin
        n_fail++;
        $display("FAIL ooo_prefix%0d: we1d=%b waddr=%h wdata=%h, required 1 %h %h",
                 i, o1d, oa, od, {1'b1, 8'(i)}, 8'h50 + 8'(i));
      end
    end
    dl_write(BASE + 18'd5, 8'h55, o1d, o1c, oa, od);
    n_checks++;
    if (o1d !== 1'b0 || o1c !== 1'b0 || err !== 1'b1 || mute !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ooo_skip: we=%b%b err=%b mute=%b ready=%b, required 00 1 1 0", o1d, o1c, err, mute, ready);
    end
    dl_write(BASE + 18'd4, 8'h54, o1d, o1c, oa, od);
    n_checks++;
    if (o1d !== 1'b0 || err !== 1'b1 || mute !== 1'b1) begin
      n_fail++;
      $display("FAIL ooo_in_fail: we1d=%b err=%b mute=%b, required 0 1 1", o1d, err, mute);
    end
    $display("test_out_of_order: done");
  endtask

  task automatic test_short_load();
    logic o1d, o1c;
    logic [8:0] oa;
    logic [7:0] od;
    int bad;
    start_session();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL short_err_cleared: err=%b, required 0", err);
    end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      dl_write(BASE + (i < 256 ? 18'(i) : 18'd512 + 18'(i - 256)), 8'(i), o1d, o1c, oa, od);
      if (o1d !== (i < 256) || o1c !== (i >= 256)) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL short_partial_strobes: %0d bad bytes, required 0", bad);
    end
    @(negedge clk);
    dl_active = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || ready !== 1'b0 || mute !== 1'b1) begin
      n_fail++;
      $display("FAIL short_drop: err=%b ready=%b mute=%b, required 1 0 1", err, ready, mute);
    end
    start_session();
    do_full_load("short_reload", 1'b0);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL short_reload_err: err=%b, required 0", err);
    end
  endtask

  task automatic test_interleave();
    start_session();
    do_full_load("interleave", 1'b1);
  endtask

  task automatic test_bank();
    @(negedge clk);
    tb_if.cpu_sel = 2'd2;
    repeat (5) @(negedge clk);
    n_checks++;
    if (tb_if.applied_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL bank_midframe: sel=%0d, required 0", tb_if.applied_sel);
    end
    tb_if.vblank = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tb_if.applied_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL bank_edge_cycle: sel=%0d, required 0", tb_if.applied_sel);
    end
    @(negedge clk);
    n_checks++;
    if (tb_if.applied_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL bank_after_edge: sel=%0d, required 2", tb_if.applied_sel);
    end
    tb_if.cpu_sel = 2'd3;
    repeat (4) @(negedge clk);
    n_checks++;
    if (tb_if.applied_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL bank_in_vblank: sel=%0d, required 2", tb_if.applied_sel);
    end
    tb_if.vblank = 1'b0;
    repeat (4) @(negedge clk);
    tb_if.vblank = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (tb_if.applied_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL bank_next_vblank: sel=%0d, required 3", tb_if.applied_sel);
    end
    $display("test_bank: applied bank %0d", tb_if.applied_sel);
  endtask

  task automatic test_reset_mid_load();
    logic o1d, o1c;
    logic [8:0] oa;
    logic [7:0] od;
    int cnt0;
    start_session();
    for (int i = 0; i < 100; i++) begin
      dl_write(BASE + 18'(i), 8'(i), o1d, o1c, oa, od);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (we1d !== 1'b0 || we1c !== 1'b0 || waddr !== 9'd0 || wdata !== 8'd0 ||
        tb_if.applied_sel !== 2'd0 || ready !== 1'b0 || mute !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_values: we=%b%b waddr=%h wdata=%h sel=%0d ready=%b mute=%b err=%b, required 00 000 00 0 0 1 0",
               we1d, we1c, waddr, wdata, tb_if.applied_sel, ready, mute, err);
    end
    rst = 1'b0;
    cnt0 = strobe_cnt;
    dl_write(BASE + 18'd0, 8'h00, o1d, o1c, oa, od);
    dl_write(BASE + 18'd100, 8'h64, o1d, o1c, oa, od);
    repeat (3) @(negedge clk);
    n_checks++;
    if (strobe_cnt !== cnt0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_strobe: strobes=%0d err=%b, required 0 0", strobe_cnt - cnt0, err);
    end
    start_session();
    do_full_load("reset_reload", 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_bank();
    test_out_of_order();
    test_short_load();
    test_interleave();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
